// File: rtl/fpu_issue_stage.sv
// Single-slot decode/issue stage feeding the FPU execute pipe.
// A destination scoreboard stalls RAW/WAW hazards; the writeback bus resolves and forwards.
module fpu_issue_stage #(
  parameter int NREG        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  output logic                   ex_valid,
  output logic [1:0]             ex_op,
  output logic [31:0]            ex_a,
  output logic [31:0]            ex_b,
  output logic [4:0]             ex_rd,
  input  logic                   ex_ready,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic            d_valid;
  logic [1:0]      d_op;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      d_rd;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic wb_hit_rd;
  logic hazard;
  logic out_free;
  logic issue_now;
  logic accept;

  // Reserved instruction bits carry no meaning for this stage.
  logic unused_reserved;
  assign unused_reserved = ^instr[19:5];

  // A writeback landing this cycle clears the hazard on its register.
  always_comb begin
    wb_hit_rs1  = wb_valid && (wb_addr == d_rs1);
    wb_hit_rs2  = wb_valid && (wb_addr == d_rs2);
    wb_hit_rd   = wb_valid && (wb_addr == d_rd);
    hazard      = d_valid && ((pending[d_rs1] && !wb_hit_rs1) ||
                              (pending[d_rs2] && !wb_hit_rs2) ||
                              (pending[d_rd]  && !wb_hit_rd));
    out_free    = !ex_valid || ex_ready;
    issue_now   = d_valid && !hazard && out_free;
    instr_ready = reset && (!d_valid || issue_now);
    accept      = instr_valid && instr_ready;
  end

  assign rf_raddr1 = d_valid ? d_rs1 : 5'd0;
  assign rf_raddr2 = d_valid ? d_rs2 : 5'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_valid <= 1'b0;
      d_op    <= 2'd0;
      d_rs1   <= 5'd0;
      d_rs2   <= 5'd0;
      d_rd    <= 5'd0;
    end else if (accept) begin
      d_valid <= 1'b1;
      d_op    <= instr[31:30];
      d_rs1   <= instr[29:25];
      d_rs2   <= instr[24:20];
      d_rd    <= instr[4:0];
    end else if (issue_now) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_op    <= 2'd0;
      ex_a     <= 32'd0;
      ex_b     <= 32'd0;
      ex_rd    <= 5'd0;
    end else if (issue_now) begin
      ex_valid <= 1'b1;
      ex_op    <= d_op;
      ex_a     <= wb_hit_rs1 ? wb_data : rf_rdata1;
      ex_b     <= wb_hit_rs2 ? wb_data : rf_rdata2;
      ex_rd    <= d_rd;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Issue-side set is applied after the writeback clear so it wins on a collision.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) pending_nxt[wb_addr] = 1'b0;
    if (issue_now) pending_nxt[d_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Bench for fpu_issue_stage: directed scenarios plus random traffic against a
// transaction-level model (in-order issue, busy-register set, architectural register values).
module tb_fpu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        ex_ready;
  logic [15:0] stall_count;

  fpu_issue_stage #(.NREG(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd),
    .ex_ready(ex_ready), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Architectural register file, updated by writebacks.
  logic [31:0] arch [32];
  assign rf_rdata1 = arch[rf_raddr1];
  assign rf_rdata2 = arch[rf_raddr2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: instruction waiting in decode, op presented to execute, busy registers.
  bit          m_dv;
  logic [31:0] m_d;
  bit          m_ev;
  logic [1:0]  m_eop;
  logic [31:0] m_ea;
  logic [31:0] m_eb;
  logic [4:0]  m_erd;
  bit          busy [32];
  logic [15:0] m_stall;
  bit          last_acc;

  typedef struct {
    logic [4:0] rd;
    int         t;
  } inflight_t;
  inflight_t exq[$];
  bit        exec_on;

  function automatic bit blocked(logic [4:0] r);
    return busy[r] && !(wb_valid && wb_addr == r);
  endfunction

  // One clock: inputs already driven at the negedge; returns at the next negedge.
  task automatic step();
    logic [4:0]  s1, s2, d;
    logic [31:0] fa, fb;
    bit          haz, issue, acc, hs;
    inflight_t   e;
    #1;
    s1    = m_d[29:25];
    s2    = m_d[24:20];
    d     = m_d[4:0];
    haz   = m_dv && (blocked(s1) || blocked(s2) || blocked(d));
    issue = m_dv && !haz && (!m_ev || ex_ready);
    acc   = instr_valid && (!m_dv || issue);
    fa    = (wb_valid && wb_addr == s1) ? wb_data : arch[s1];
    fb    = (wb_valid && wb_addr == s2) ? wb_data : arch[s2];
    hs    = m_ev && ex_ready;
    chk("instr_ready", instr_ready, !m_dv || issue);
    chk("rf_raddr1", rf_raddr1, m_dv ? s1 : 5'd0);
    chk("rf_raddr2", rf_raddr2, m_dv ? s2 : 5'd0);
    @(posedge clk);
    #1;
    if (haz && m_stall != 16'hFFFF) m_stall++;
    if (hs) begin
      m_ev = 0;
      if (exec_on) begin
        e.rd = m_erd;
        e.t  = int'($urandom_range(1, 5));
        exq.push_back(e);
      end
    end
    if (issue) begin
      m_ev  = 1;
      m_eop = m_d[31:30];
      m_ea  = fa;
      m_eb  = fb;
      m_erd = d;
    end
    if (wb_valid) begin
      busy[wb_addr] = 0;
      arch[wb_addr] = wb_data;
    end
    if (issue) begin
      busy[d] = 1;
      m_dv    = 0;
    end
    if (acc) begin
      m_dv = 1;
      m_d  = instr;
    end
    last_acc = acc;
    chk("ex_valid", ex_valid, m_ev);
    if (m_ev) begin
      chk("ex_op", ex_op, m_eop);
      chk("ex_a", ex_a, m_ea);
      chk("ex_b", ex_b, m_eb);
      chk("ex_rd", ex_rd, m_erd);
    end
    chk("stall_count", stall_count, m_stall);
    @(negedge clk);
  endtask

  task automatic drive(bit iv, logic [31:0] ins, bit er, bit wv, logic [4:0] wa, logic [31:0] wd);
    instr_valid = iv;
    instr       = ins;
    ex_ready    = er;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    step();
  endtask

  // Execute-stage stand-in: each accepted op writes back after a random delay.
  task automatic exec_drive();
    int pick = -1;
    foreach (exq[i]) begin
      exq[i].t--;
      if (pick < 0 && exq[i].t <= 0) pick = i;
    end
    wb_valid = 0;
    wb_addr  = 0;
    wb_data  = 0;
    if (pick >= 0) begin
      wb_valid = 1;
      wb_addr  = exq[pick].rd;
      wb_data  = $urandom;
      exq.delete(pick);
    end
  endtask

  task automatic do_reset();
    reset       = 0;
    instr_valid = 0;
    wb_valid    = 0;
    ex_ready    = 1;
    @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_ready", instr_ready, 0);
    chk("rst_ex_op", ex_op, 0);
    chk("rst_ex_a", ex_a, 0);
    chk("rst_ex_b", ex_b, 0);
    chk("rst_ex_rd", ex_rd, 0);
    m_dv    = 0;
    m_ev    = 0;
    m_stall = 0;
    foreach (busy[i]) busy[i] = 0;
    exq.delete();
    @(negedge clk);
    reset = 1;
  endtask

  logic [31:0] t3ops [3];
  logic [31:0] ri;
  int          k;

  initial begin
    foreach (arch[i]) arch[i] = 32'h1000_0000 + i;
    arch[1]     = 32'h3f80_0000;
    arch[2]     = 32'h4000_0000;
    reset       = 0;
    instr_valid = 0;
    instr       = 0;
    wb_valid    = 0;
    wb_addr     = 0;
    wb_data     = 0;
    ex_ready    = 1;
    exec_on     = 0;
    m_d         = 0;
    @(negedge clk);
    do_reset();

    // Plain add, 2-edge latency.
    drive(1, 32'h0220_0003, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("t1_valid", ex_valid, 1);
    chk("t1_op", ex_op, 0);
    chk("t1_a", ex_a, 32'h3f80_0000);
    chk("t1_b", ex_b, 32'h4000_0000);
    chk("t1_rd", ex_rd, 3);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 3, 32'h1111_0000);

    // RAW through a slow divide, resolved by forwarding.
    drive(1, 32'h8220_0003, 1, 0, 0, 0);
    drive(1, 32'h0610_0004, 1, 0, 0, 0);
    repeat (5) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 3, 32'h4040_0000);
    chk("t2_a_fwd", ex_a, 32'h4040_0000);
    chk("t2_rd", ex_rd, 4);
    chk("t2_stall", stall_count, 5);

    // Backpressure with three independent ops offered.
    t3ops[0] = 32'h0220_000A;
    t3ops[1] = 32'hC220_000B;
    t3ops[2] = 32'h4410_000C;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive(k < 3, (k < 3) ? t3ops[k] : 32'h0, !(c >= 1 && c <= 4), 0, 0, 0);
      if (last_acc) k++;
    end
    chk("t3_stall_unchanged", stall_count, 5);

    // WAW on r5, then a reader of r5 waits on the sub.
    drive(1, 32'hC220_0005, 1, 0, 0, 0);
    drive(1, 32'h4220_0005, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 5, 32'h4100_0000);
    chk("t4_op", ex_op, 1);
    chk("t4_rd", ex_rd, 5);
    drive(1, 32'h0A10_0006, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 5, 32'h4120_0000);
    drive(0, 0, 1, 0, 0, 0);

    // Reset with a held op, a full slot and r3 pending.
    drive(1, 32'h0220_0003, 1, 0, 0, 0);
    drive(1, 32'h0220_0009, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 32'h0610_0006, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("t5_issue", ex_valid, 1);
    chk("t5_stall", stall_count, 0);
    drive(0, 0, 1, 1, 3, 32'h1234_5678);
    drive(0, 0, 1, 1, 6, 32'h0bad_cafe);

    // Random traffic over a small register window to provoke hazards.
    do_reset();
    exec_on = 1;
    for (int c = 0; c < 1500; c++) begin
      ri          = $urandom;
      ri[29:25]   = 5'($urandom_range(0, 7));
      ri[24:20]   = 5'($urandom_range(0, 7));
      ri[4:0]     = 5'($urandom_range(0, 7));
      instr_valid = ($urandom_range(0, 3) != 0);
      instr       = ri;
      ex_ready    = ($urandom_range(0, 3) != 0);
      exec_drive();
      step();
    end
    instr_valid = 0;
    ex_ready    = 1;
    for (int c = 0; c < 300 && (exq.size() > 0 || m_dv || m_ev); c++) begin
      exec_drive();
      step();
    end
    chk("drain_done", (exq.size() == 0 && !m_dv && !m_ev), 1);
    exec_on = 0;

    // Reserved bits ignored, then a permanent stall saturates the counter.
    drive(1, 32'h0220_7FE3, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("t6_op", ex_op, 0);
    chk("t6_rd", ex_rd, 3);
    chk("t6_a", ex_a, arch[1]);
    chk("t6_b", ex_b, arch[2]);
    drive(1, 32'h0610_0006, 1, 0, 0, 0);
    for (int c = 0; c < 70000; c++) drive(0, 0, 1, 0, 0, 0);
    chk("t6_saturate", stall_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
